// File: rtl/mac_acc_drain_if.sv
// mac_acc_drain_if: MAC accumulator capture and result stream bundle.
// master = drain block; slave = MAC row plus result write-back path.
interface mac_acc_drain_if #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 32
);
  localparam int IW = $clog2(N);

  logic [N*ACC_W-1:0] acc_i;
  logic               done_i;
  logic               drain_ready;
  logic               mac_clr;
  logic               res_valid;
  logic               res_ready;
  logic [OUT_W-1:0]   res_data;
  logic [IW-1:0]      res_idx;
  logic               res_last;
  logic               sat_o;

  modport master (
    input  acc_i, done_i, res_ready,
    output drain_ready, mac_clr,
    output res_valid, res_data, res_idx,
    output res_last, sat_o
  );

  modport slave (
    output acc_i, done_i, res_ready,
    input  drain_ready, mac_clr,
    input  res_valid, res_data, res_idx,
    input  res_last, sat_o
  );
endinterface

// File: rtl/mac_acc_drain.sv
// mac_acc_drain: snapshots N MAC accumulators, clears the row, streams results.
// Define MAC_DRAIN_SAT_EN to clamp (instead of truncate) into OUT_W bits.
module mac_acc_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 32
) (
  input logic              clk,
  input logic              rst,
  mac_acc_drain_if.master  bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    nxt;
  logic [OUT_W-1:0] cap [N];
  logic             sat [N];
  logic [OUT_W-1:0] conv [N];
  logic             csat [N];
  logic [OUT_W-1:0] data_q;
  logic             vld_q;
  logic             last_q;
  logic             sat_q;
  logic             clr_q;
  logic             rdy_q;

  for (genvar g = 0; g < N; g++) begin : g_conv
    logic [ACC_W-1:0] a;
    assign a = bus.acc_i[g*ACC_W +: ACC_W];
`ifdef MAC_DRAIN_SAT_EN
    localparam int HW = ACC_W - OUT_W + 1;
    localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
    logic [HW-1:0] hi;
    logic          inr;
    // In range iff the bits above the output sign are a pure sign extension
    assign hi      = a[ACC_W-1 -: HW];
    assign inr     = (hi == '0) || (hi == '1);
    assign csat[g] = !inr;
    assign conv[g] = inr ? a[OUT_W-1:0]
                   : (a[ACC_W-1] ? MINV : MAXV);
`else
    logic unused_hi;
    assign unused_hi = ^a;
    assign conv[g]   = a[OUT_W-1:0];
    assign csat[g]   = 1'b0;
`endif
  end

  assign nxt = idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      sat_q  <= 1'b0;
      clr_q  <= 1'b0;
      rdy_q  <= 1'b1;
      for (int i = 0; i < N; i++) begin
        cap[i] <= '0;
        sat[i] <= 1'b0;
      end
    end else begin
      clr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.done_i && rdy_q) begin
            for (int i = 0; i < N; i++) begin
              cap[i] <= conv[i];
              sat[i] <= csat[i];
            end
            data_q <= conv[0];
            sat_q  <= csat[0];
            idx    <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b1;
            rdy_q  <= 1'b0;
            clr_q  <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (bus.res_ready) begin
            if (last_q) begin
              state  <= IDLE;
              idx    <= '0;
              data_q <= '0;
              vld_q  <= 1'b0;
              last_q <= 1'b0;
              sat_q  <= 1'b0;
              rdy_q  <= 1'b1;
            end else begin
              idx    <= nxt;
              data_q <= cap[nxt];
              sat_q  <= sat[nxt];
              last_q <= (nxt == IW'(N-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.drain_ready = rdy_q;
  assign bus.mac_clr     = clr_q;
  assign bus.res_valid   = vld_q;
  assign bus.res_data    = data_q;
  assign bus.res_idx     = idx;
  assign bus.res_last    = last_q;
  assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_mac_acc_drain.sv
// tb_mac_acc_drain: directed frames against a queue of expected beats.
// Build with or without +define+MAC_DRAIN_SAT_EN; the expected model follows.
module tb_mac_acc_drain;
  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int IW    = 2;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [IW-1:0]    idx;
    logic             last;
    logic             sat;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  int    clr_cnt;
  int    hs_cnt;
  logic  m_send;
  logic  m_clr;
  beat_t q[$];
  logic  pat [7];

  mac_acc_drain_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  mac_acc_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] a, input int i);
    beat_t b;
    int signed v;
    v      = a;
    b.idx  = i[IW-1:0];
    b.last = (i == N-1);
`ifdef MAC_DRAIN_SAT_EN
    if (v > 32767) begin
      b.d = 16'h7FFF; b.sat = 1'b1;
    end else if (v < -32768) begin
      b.d = 16'h8000; b.sat = 1'b1;
    end else begin
      b.d = a[15:0]; b.sat = 1'b0;
    end
`else
    b.d   = a[15:0];
    b.sat = 1'b0;
`endif
    return b;
  endfunction

  // Advance one clock: update the model with the inputs about to be
  // sampled, then compare the DUT against it on the falling edge.
  task automatic step();
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) hs_cnt++;
    if (rst) begin
      q.delete();
      m_send = 1'b0;
      m_clr  = 1'b0;
    end else if (!m_send) begin
      m_clr = 1'b0;
      if (bus.done_i) begin
        for (int i = 0; i < N; i++)
          q.push_back(mk(bus.acc_i[i*ACC_W +: ACC_W], i));
        m_send = 1'b1;
        m_clr  = 1'b1;
      end
    end else begin
      m_clr = 1'b0;
      if (bus.res_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_send = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (bus.mac_clr === 1'b1) clr_cnt++;
    chk("drain_ready", bus.drain_ready, !m_send);
    chk("mac_clr", bus.mac_clr, m_clr);
    chk("res_valid", bus.res_valid, m_send);
    if (m_send) begin
      chk("res_data", bus.res_data, q[0].d);
      chk("res_idx", bus.res_idx, q[0].idx);
      chk("res_last", bus.res_last, q[0].last);
      chk("sat_o", bus.sat_o, q[0].sat);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_drain_ready", bus.drain_ready, 1);
    chk("rst_mac_clr", bus.mac_clr, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_idx", bus.res_idx, 0);
    chk("rst_res_last", bus.res_last, 0);
    chk("rst_sat_o", bus.sat_o, 0);
  endtask

  task automatic frame(input logic [N*ACC_W-1:0] acc);
    bus.acc_i     = acc;
    bus.done_i    = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.done_i = 1'b0;
    for (int i = 0; i < N + 1; i++) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.acc_i     = '0;
    bus.done_i    = 1'b0;
    bus.res_ready = 1'b0;
    m_send        = 1'b0;
    m_clr         = 1'b0;
    clr_cnt       = 0;
    hs_cnt        = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);

    // 1: reset
    step();
    step();
    chk_reset_outs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t1_clr_cnt", clr_cnt, 0);

    // 2: basic frame, ready held high
    clr_cnt = 0; hs_cnt = 0;
    frame({32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFF0, 32'h00000010});
    chk("t2_clr_cnt", clr_cnt, 1);
    chk("t2_beats", hs_cnt, N);

    // 3: backpressure pattern
    clr_cnt = 0; hs_cnt = 0;
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.res_ready = pat[i];
      step();
    end
    bus.res_ready = 1'b1;
    step();
    chk("t3_clr_cnt", clr_cnt, 1);
    chk("t3_beats", hs_cnt, N);

    // 4: out-of-range accumulators
    clr_cnt = 0; hs_cnt = 0;
    frame({32'h00000000, 32'h00000005, 32'hFFFE0000, 32'h00012345});
    chk("t4_beats", hs_cnt, N);

    // 5: done_i held across two frames
    clr_cnt = 0; hs_cnt = 0;
    bus.acc_i     = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
    bus.done_i    = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.acc_i = {32'hFFFFFFFC, 32'h00001234, 32'h00000042, 32'hFFFFFF00};
    for (int i = 0; i < N; i++) step();
    step();
    bus.done_i = 1'b0;
    for (int i = 0; i < N + 1; i++) step();
    chk("t5_clr_cnt", clr_cnt, 2);
    chk("t5_beats", hs_cnt, 2 * N);

    // 6: reset after the second beat, then a clean frame
    clr_cnt = 0; hs_cnt = 0;
    bus.acc_i  = {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011};
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk_reset_outs();
    rst = 1'b0;
    hs_cnt = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_no_beats", hs_cnt, 0);
    frame({32'h00000088, 32'h00000077, 32'h00000066, 32'h00000055});
    chk("t6_beats", hs_cnt, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
